// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16-pin PWM output stage driven by the SPI register block.
//   clk, rst            : clock and asynchronous active-high reset
//   en_reg_out_*        : per-pin output enable (0 = pin forced low)
//   en_reg_pwm_*        : per-pin mode (0 = forced high, 1 = PWM waveform)
//   pwm_duty_cycle      : global duty, 0x00 = 0%, 0xFF = 100%
//   pwm_out             : registered pin drive, bit i = pin i
//   period_start        : one-clk pulse in the cycle after the counter wraps
//   Define PWM_SYNC_UPDATE_EN to latch the duty only at period boundaries.
module pwm_peripheral #(
    parameter int CLK_DIV = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] pwm_out,
    output logic        period_start
);
    localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [PW-1:0] prescaler;
    logic [7:0]    pwm_counter;
    logic [7:0]    duty;
    logic [15:0]   en_out;
    logic [15:0]   en_pwm;
    logic          tick;
    logic          wrap;
    logic          w;
    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign tick   = prescaler == PW'(CLK_DIV - 1);
    assign wrap   = tick && pwm_counter == 8'hFF;
    // 0xFF is special-cased so full duty never shows a low cycle at counter 255
    assign w      = duty == 8'hFF || pwm_counter < duty;
`ifdef PWM_SYNC_UPDATE_EN
    logic [7:0] duty_q;
    logic       loaded;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= 8'h00;
            loaded <= 1'b0;
        end else begin
            loaded <= 1'b1;
            if (wrap || !loaded)
                duty_q <= pwm_duty_cycle;
        end
    end
    assign duty = duty_q;
`else
    assign duty = pwm_duty_cycle;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler    <= '0;
            pwm_counter  <= 8'h00;
            period_start <= 1'b0;
            pwm_out      <= 16'h0000;
        end else begin
            prescaler    <= tick ? '0 : prescaler + 1'b1;
            pwm_counter  <= pwm_counter + {7'd0, tick};
            period_start <= wrap;
            pwm_out      <= en_out & (~en_pwm | {16{w}});
        end
    end
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: scoreboard bench for pwm_peripheral with CLK_DIV=2.
module tb_pwm_peripheral;
    localparam int CLK_DIV = 2;
`ifdef PWM_SYNC_UPDATE_EN
    localparam int T5_CUR = 128;
`else
    localparam int T5_CUR = 384;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] en_out = 16'h0000;
    logic [15:0] en_pwm = 16'h0000;
    logic [7:0]  duty = 8'h00;
    logic [15:0] pwm_out;
    logic        period_start;
    int          checks = 0;
    int          errors = 0;
    int          cyc;

    typedef struct packed {
        logic [63:0] name;
        logic [15:0] out;
        logic        ps;
    } imm_t;
    typedef struct packed {
        logic [63:0]      name;
        logic             first;
        logic [15:0][9:0] high;
    } per_t;
    imm_t imm_q[$];
    per_t per_q[$];

    pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk),
        .rst(rst),
        .en_reg_out_7_0(en_out[7:0]),
        .en_reg_out_15_8(en_out[15:8]),
        .en_reg_pwm_7_0(en_pwm[7:0]),
        .en_reg_pwm_15_8(en_pwm[15:8]),
        .pwm_duty_cycle(duty),
        .pwm_out(pwm_out),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else cyc <= cyc + 1;

    task automatic expect_now(input logic [63:0] n, input logic [15:0] o, input logic p);
        imm_t t;
        t.name = n;
        t.out = o;
        t.ps = p;
        imm_q.push_back(t);
    endtask

    task automatic expect_period(input logic [63:0] n, input logic [15:0] pwm_mask, input int hi, input logic [15:0] one_mask);
        per_t t;
        t.name = n;
        t.first = 1'b0;
        for (int i = 0; i < 16; i++)
            t.high[i] = pwm_mask[i] ? 10'(hi) : one_mask[i] ? 10'd512 : 10'd0;
        per_q.push_back(t);
    endtask

    task automatic expect_first(input logic [63:0] n);
        per_t t;
        t.name = n;
        t.first = 1'b1;
        t.high = '0;
        per_q.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ps();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 3000);
        if (!period_start) begin
            errors++;
            $display("FAIL wait_ps: no period_start within %0d cycles, required one", n);
        end
    endtask

    task automatic measure(input logic [63:0] n, input logic [15:0] pwm_mask, input int hi, input logic [15:0] one_mask);
        wait_ps();
        wait_ps();
        @(posedge clk);
        expect_period(n, pwm_mask, hi, one_mask);
        wait_ps();
    endtask

    initial begin
        int len;
        logic [15:0][9:0] hc;
        imm_t a;
        per_t p;
        len = 0;
        hc = '0;
        forever begin
            @(negedge clk);
            while (imm_q.size() > 0) begin
                a = imm_q.pop_front();
                checks++;
                if (pwm_out !== a.out || period_start !== a.ps) begin
                    errors++;
                    $display("FAIL %s: pwm_out=%h period_start=%b, required %h %b", a.name, pwm_out, period_start, a.out, a.ps);
                end
            end
            if (rst) begin
                len = 0;
                hc = '0;
            end else if (period_start) begin
                if (per_q.size() > 0) begin
                    p = per_q.pop_front();
                    if (p.first) begin
                        checks++;
                        if (cyc != 512) begin
                            errors++;
                            $display("FAIL %s: first period_start after %0d clk, required 512", p.name, cyc);
                        end
                    end else begin
                        checks++;
                        if (len != 512) begin
                            errors++;
                            $display("FAIL %s len: period %0d clk, required 512", p.name, len);
                        end
                        for (int i = 0; i < 16; i++) begin
                            checks++;
                            if (hc[i] != p.high[i]) begin
                                errors++;
                                $display("FAIL %s pin %0d: high %0d clk, required %0d", p.name, i, hc[i], p.high[i]);
                            end
                        end
                    end
                end
                len = 1;
                for (int i = 0; i < 16; i++) hc[i] = 10'(pwm_out[i]);
            end else begin
                len++;
                for (int i = 0; i < 16; i++) hc[i] = hc[i] + 10'(pwm_out[i]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        expect_now("rst", 16'h0000, 1'b0);
        step();
        rst = 1'b0;
        expect_first("first");
        step();
        en_out = 16'h0001;
        expect_now("t2_pre", 16'h0000, 1'b0);
        step();
        expect_now("t2_on", 16'h0001, 1'b0);
        en_out = 16'h0000;
        step();
        expect_now("t2_off", 16'h0000, 1'b0);
        wait_ps();
        step();
        en_out = 16'h8001;
        en_pwm = 16'h8001;
        duty = 8'h80;
        measure("t3_d80", 16'h8001, 256, 16'h0000);
        step();
        expect_now("t3_k1", 16'h8001, 1'b0);
        repeat (255) step();
        expect_now("t3_k256", 16'h8001, 1'b0);
        step();
        expect_now("t3_k257", 16'h0000, 1'b0);
        duty = 8'h00;
        measure("t4_d00", 16'h8001, 0, 16'h0000);
        step();
        duty = 8'hFF;
        measure("t4_dff", 16'h8001, 512, 16'h0000);
        step();
        duty = 8'h01;
        measure("t4_d01", 16'h8001, 2, 16'h0000);
        step();
        en_out = 16'h00FF;
        en_pwm = 16'h000F;
        duty = 8'h40;
        measure("t6", 16'h000F, 128, 16'h00F0);
        step();
        en_out = 16'h8001;
        en_pwm = 16'h8001;
        measure("t5_base", 16'h8001, 128, 16'h0000);
        step();
        expect_period("t5_cur", 16'h8001, T5_CUR, 16'h0000);
        repeat (31) step();
        duty = 8'hC0;
        wait_ps();
        step();
        expect_period("t5_next", 16'h8001, 384, 16'h0000);
        wait_ps();
        step();
        en_out = 16'h0001;
        en_pwm = 16'h0000;
        step();
        expect_now("t1_hi", 16'h0001, 1'b0);
        repeat (100) step();
        rst = 1'b1;
        expect_now("t1_rst", 16'h0000, 1'b0);
        repeat (3) step();
        rst = 1'b0;
        expect_first("t1_first");
        wait_ps();
        repeat (2) step();
        checks++;
        if (imm_q.size() != 0 || per_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expectations left, required 0/0", imm_q.size(), per_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
